// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-way round-robin bus arbiter.
package arb_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic logic [NUM_REQ-1:0] onehot4(input logic [1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Combinational round-robin picker: first set request after ptr, wrapping, ptr itself last.
module rr_pick_4
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic               found,
  output logic [1:0]         winner
);

  logic [1:0] idx;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    found  = 1'b0;
    winner = 2'd0;
    idx    = 2'd0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_4.sv
// Round-robin arbiter sharing one downstream channel between 4 requesters, with burst
// hold until last beat, owner withdrawal, or a fairness beat limit.
module bus_arbiter_4
  import arb_pkg::*;
#(
  parameter int MAX_BEATS = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] last,
  input  logic               out_ready,
  output logic [NUM_REQ-1:0] grant,
  output logic [1:0]         select,
  output logic               out_valid,
  output logic [NUM_REQ-1:0] req_ready,
  output logic               busy
);

  localparam int CNT_WIDTH = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(MAX_BEATS - 1);

  arb_state_t           state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [1:0]           select_q, select_d;
  logic [1:0]           ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  logic       found;
  logic [1:0] winner;
  logic       beat;
  logic       release_now;

  rr_pick_4 u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .found  (found),
    .winner (winner)
  );

  assign busy      = (state_q == GRANT);
  assign out_valid = busy & req[select_q];
  // grant_q is all-zero when idle, so masking it gives the owner-only ready.
  assign req_ready = grant_q & {NUM_REQ{out_ready}};
  assign grant     = grant_q;
  assign select    = select_q;

  assign beat        = busy & req[select_q] & out_ready;
  assign release_now = (beat & last[select_q])
                     | (beat & (count_q == LAST_CNT))
                     | ~req[select_q];

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    select_d = select_q;
    ptr_d    = ptr_q;
    count_d  = count_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d  = GRANT;
          grant_d  = onehot4(winner);
          select_d = winner;
          count_d  = '0;
        end
      end
      GRANT: begin
        // select is left alone on release; the mux output is ignored while idle.
        if (release_now) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = select_q;
          count_d = '0;
        end else if (beat) begin
          count_d = count_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      select_q <= 2'd0;
      ptr_q    <= 2'd3;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      select_q <= select_d;
      ptr_q    <= ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_4.sv
// Self-checking bench for bus_arbiter_4 (MAX_BEATS=4): vector table through a scoreboard
// queue plus a hand-written asynchronous-reset sequence.
module tb_bus_arbiter_4;

  logic       clk;
  logic       reset_n;
  logic [3:0] req;
  logic [3:0] last;
  logic       out_ready;
  logic [3:0] grant;
  logic [1:0] select;
  logic       out_valid;
  logic [3:0] req_ready;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] last;
    logic       ordy;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       ov;
    logic [3:0] rr;
    logic       busy;
  } vec_t;

  typedef struct {
    int         row;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       ov;
    logic [3:0] rr;
    logic       busy;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  bus_arbiter_4 #(.MAX_BEATS(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .last      (last),
    .out_ready (out_ready),
    .grant     (grant),
    .select    (select),
    .out_valid (out_valid),
    .req_ready (req_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] r, input logic [3:0] l, input logic o,
                     input logic [3:0] g, input logic [1:0] s, input logic v,
                     input logic [3:0] rr, input logic b);
    vec_t t;
    t.req = r; t.last = l; t.ordy = o;
    t.grant = g; t.sel = s; t.ov = v; t.rr = rr; t.busy = b;
    vecs.push_back(t);
  endtask

  task automatic check_outs(input string tag, input logic [3:0] g, input logic [1:0] s,
                            input logic v, input logic [3:0] rr, input logic b);
    check({tag, " grant"},     8'(grant),     8'(g));
    check({tag, " select"},    8'(select),    8'(s));
    check({tag, " out_valid"}, 8'(out_valid), 8'(v));
    check({tag, " req_ready"}, 8'(req_ready), 8'(rr));
    check({tag, " busy"},      8'(busy),      8'(b));
  endtask

  initial begin
    exp_t e;
    reset_n   = 1'b0;
    req       = '0;
    last      = '0;
    out_ready = 1'b0;

    // Full round robin from reset, one-beat bursts: 0,1,2,3,0 with dead cycles
    add(4'b1111, 4'b1111, 1, 4'b0000, 0, 0, 4'b0000, 0);
    add(4'b1111, 4'b1111, 1, 4'b0001, 0, 1, 4'b0001, 1);
    add(4'b1111, 4'b1111, 1, 4'b0000, 0, 0, 4'b0000, 0);
    add(4'b1111, 4'b1111, 1, 4'b0010, 1, 1, 4'b0010, 1);
    add(4'b1111, 4'b1111, 1, 4'b0000, 1, 0, 4'b0000, 0);
    add(4'b1111, 4'b1111, 1, 4'b0100, 2, 1, 4'b0100, 1);
    add(4'b1111, 4'b1111, 1, 4'b0000, 2, 0, 4'b0000, 0);
    add(4'b1111, 4'b1111, 1, 4'b1000, 3, 1, 4'b1000, 1);
    add(4'b1111, 4'b1111, 1, 4'b0000, 3, 0, 4'b0000, 0);
    add(4'b1111, 4'b1111, 1, 4'b0001, 0, 1, 4'b0001, 1);
    add(4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 0);
    // Requester 0 alone, three beats ending on last
    add(4'b0001, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 0);
    add(4'b0001, 4'b0000, 1, 4'b0001, 0, 1, 4'b0001, 1);
    add(4'b0001, 4'b0000, 1, 4'b0001, 0, 1, 4'b0001, 1);
    add(4'b0001, 4'b0001, 1, 4'b0001, 0, 1, 4'b0001, 1);
    add(4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 0);
    // Requester 2 forced out after 4 beats; non-owner req/last ignored; 1 wins next
    add(4'b0100, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 0);
    add(4'b0110, 4'b0010, 1, 4'b0100, 2, 1, 4'b0100, 1);
    add(4'b0110, 4'b0010, 1, 4'b0100, 2, 1, 4'b0100, 1);
    add(4'b0110, 4'b0000, 1, 4'b0100, 2, 1, 4'b0100, 1);
    add(4'b0110, 4'b0000, 1, 4'b0100, 2, 1, 4'b0100, 1);
    add(4'b0110, 4'b0000, 1, 4'b0000, 2, 0, 4'b0000, 0);
    // Owner 1 stalled by out_ready=0; last without a beat ignored; then one beat releases
    add(4'b0110, 4'b0000, 0, 4'b0010, 1, 1, 4'b0000, 1);
    add(4'b0110, 4'b0000, 0, 4'b0010, 1, 1, 4'b0000, 1);
    add(4'b0110, 4'b0000, 0, 4'b0010, 1, 1, 4'b0000, 1);
    add(4'b0110, 4'b0000, 0, 4'b0010, 1, 1, 4'b0000, 1);
    add(4'b0110, 4'b0010, 0, 4'b0010, 1, 1, 4'b0000, 1);
    add(4'b0110, 4'b0010, 1, 4'b0010, 1, 1, 4'b0010, 1);
    add(4'b0110, 4'b0000, 1, 4'b0000, 1, 0, 4'b0000, 0);
    add(4'b0000, 4'b0000, 1, 4'b0100, 2, 0, 4'b0100, 1);
    add(4'b0000, 4'b0000, 1, 4'b0000, 2, 0, 4'b0000, 0);
    // Owner 3 withdraws mid-burst; next arbitration starts at requester 0
    add(4'b1000, 4'b0000, 1, 4'b0000, 2, 0, 4'b0000, 0);
    add(4'b1000, 4'b0000, 1, 4'b1000, 3, 1, 4'b1000, 1);
    add(4'b0001, 4'b0001, 1, 4'b1000, 3, 0, 4'b1000, 1);
    add(4'b0011, 4'b0000, 1, 4'b0000, 3, 0, 4'b0000, 0);
    add(4'b0011, 4'b0001, 1, 4'b0001, 0, 1, 4'b0001, 1);
    add(4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 0);

    #12;
    check_outs("reset", 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      @(posedge clk);
      #1;
      req       = vecs[k].req;
      last      = vecs[k].last;
      out_ready = vecs[k].ordy;
      e.row = k; e.grant = vecs[k].grant; e.sel = vecs[k].sel;
      e.ov = vecs[k].ov; e.rr = vecs[k].rr; e.busy = vecs[k].busy;
      exp_q.push_back(e);
      @(negedge clk);
      if (exp_q.size() == 0) begin
        check("scoreboard empty", 8'd0, 8'd1);
      end else begin
        e = exp_q.pop_front();
        check_outs($sformatf("row%0d", e.row), e.grant, e.sel, e.ov, e.rr, e.busy);
      end
    end

    // Asynchronous reset in the middle of a burst
    @(posedge clk);
    #1;
    req = 4'b0100; last = 4'b0000; out_ready = 1'b1;
    @(negedge clk);
    check("pre-burst busy", 8'(busy), 8'd0);
    @(posedge clk);
    #1;
    check_outs("burst", 4'b0100, 2'd2, 1'b1, 4'b0100, 1'b1);
    #3;
    reset_n = 1'b0;
    #1;
    check_outs("async reset", 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);
    req = 4'b1000;
    @(negedge clk);
    check("held in reset busy", 8'(busy), 8'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_outs("after reset", 4'b1000, 2'd3, 1'b1, 4'b1000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
